// File: rtl/s4ga_pkg.sv
// Shared s4ga stream geometry and streamer state encoding; the receiver uses
// the same derivations so both ends of the config stream agree on framing.
package s4ga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    STREAM
  } state_t;

  function automatic int unsigned seg_ceil(input int unsigned bits, input int unsigned si_w);
    return (bits + si_w - 1) / si_w;
  endfunction

  function automatic int unsigned idx_segs(input int unsigned n, input int unsigned si_w);
    return seg_ceil($clog2(n), si_w);
  endfunction

  function automatic int unsigned mask_segs(input int unsigned k, input int unsigned si_w);
    return seg_ceil(1 << k, si_w);
  endfunction

  function automatic int unsigned segs(input int unsigned n, input int unsigned k,
                                       input int unsigned si_w);
    return k * idx_segs(n, si_w) + mask_segs(k, si_w);
  endfunction

  function automatic int unsigned cfg_w(input int unsigned n, input int unsigned k,
                                        input int unsigned si_w);
    return segs(n, k, si_w) * si_w;
  endfunction

endpackage

// File: rtl/s4ga_cfg_ram.sv
// LUT config store: one write port, one registered read port that returns
// the pre-write contents when read and write hit the same entry.
module s4ga_cfg_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned WIDTH  = 48,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// Streams stored LUT configs to the s4ga fabric as SI_W-bit segments, MSB
// first, after an N-cycle fabric flush; loops over all LUTs until stopped.
module s4ga_cfg_streamer
  import s4ga_pkg::*;
#(
  parameter int unsigned N    = 64,
  parameter int unsigned K    = 4,
  parameter int unsigned SI_W = 4,
  localparam int unsigned N_W   = $clog2(N),
  localparam int unsigned SEGS  = segs(N, K, SI_W),
  localparam int unsigned CFG_W = cfg_w(N, K, SI_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [N_W-1:0]   wr_addr,
  input  logic [CFG_W-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  output logic [SI_W-1:0]  si_out,
  output logic             ga_rst_out,
  output logic [N_W-1:0]   lut_n,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned SEG_CW = $clog2(SEGS);

  state_t              state_q, state_d;
  logic [N_W-1:0]      flush_q, flush_d;
  logic [SEG_CW-1:0]   seg_q, seg_d;
  logic [N_W-1:0]      lut_q, lut_d, lut_next;
  logic [CFG_W-1:0]    shreg_q, shreg_d;
  logic                ga_rst_q, ga_rst_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                stop_q, stop_d;
  logic                stop_seen;
  logic                rd_en;
  logic [N_W-1:0]      rd_addr;
  logic [CFG_W-1:0]    rd_data;

  s4ga_cfg_ram #(
    .DEPTH(N),
    .WIDTH(CFG_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign lut_next  = (lut_q == N_W'(N - 1)) ? '0 : lut_q + 1'b1;
  assign stop_seen = stop_q | stop;

  // The RAM read for the next word is issued one cycle before it is needed,
  // so the load at the word boundary sees registered read data with no bubble.
  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    seg_d        = seg_q;
    lut_d        = lut_q;
    shreg_d      = shreg_q;
    ga_rst_d     = ga_rst_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    stop_d       = stop_q;
    rd_en        = 1'b0;
    rd_addr      = lut_next;
    unique case (state_q)
      IDLE: begin
        ga_rst_d = 1'b1;
        busy_d   = 1'b0;
        shreg_d  = '0;
        lut_d    = '0;
        seg_d    = '0;
        flush_d  = '0;
        stop_d   = 1'b0;
        if (start && !stop) begin
          state_d = FLUSH;
          busy_d  = 1'b1;
        end
      end
      FLUSH: begin
        stop_d  = stop_seen;
        flush_d = flush_q + 1'b1;
        if (flush_q == N_W'(N - 2)) begin
          rd_en   = 1'b1;
          rd_addr = '0;
        end
        if (flush_q == N_W'(N - 1)) begin
          flush_d = '0;
          if (stop_seen) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            stop_d  = 1'b0;
          end else begin
            state_d  = STREAM;
            ga_rst_d = 1'b0;
            shreg_d  = rd_data;
            seg_d    = '0;
            lut_d    = '0;
          end
        end
      end
      STREAM: begin
        stop_d  = stop_seen;
        seg_d   = seg_q + 1'b1;
        shreg_d = shreg_q << SI_W;
        if (seg_q == SEG_CW'(SEGS - 2)) begin
          rd_en        = 1'b1;
          frame_done_d = (lut_q == N_W'(N - 1));
        end
        if (seg_q == SEG_CW'(SEGS - 1)) begin
          seg_d = '0;
          if (stop_seen) begin
            state_d  = IDLE;
            ga_rst_d = 1'b1;
            busy_d   = 1'b0;
            lut_d    = '0;
            shreg_d  = '0;
            stop_d   = 1'b0;
          end else begin
            lut_d   = lut_next;
            shreg_d = rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_q      <= '0;
      seg_q        <= '0;
      lut_q        <= '0;
      shreg_q      <= '0;
      ga_rst_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      seg_q        <= seg_d;
      lut_q        <= lut_d;
      shreg_q      <= shreg_d;
      ga_rst_q     <= ga_rst_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      stop_q       <= stop_d;
    end
  end

  assign si_out     = shreg_q[CFG_W-1 -: SI_W];
  assign ga_rst_out = ga_rst_q;
  assign lut_n      = lut_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// Directed bench for s4ga_cfg_streamer: flush, framing, wrap, live rewrites,
// stop handling and mid-stream reset.
module tb_s4ga_cfg_streamer;

  localparam int unsigned N     = 64;
  localparam int unsigned K     = 4;
  localparam int unsigned SI_W  = 4;
  localparam int unsigned CFG_W = 48;
  localparam int unsigned SEGS  = 12;
  localparam int unsigned FRAME = N * SEGS;

  logic              clk = 1'b0;
  logic              rst, wr_en, start, stop;
  logic [5:0]        wr_addr;
  logic [CFG_W-1:0]  wr_data;
  logic [SI_W-1:0]   si_out;
  logic              ga_rst_out, frame_done, busy;
  logic [5:0]        lut_n;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  logic [CFG_W-1:0] exp_cfg [N];
  logic [3:0] lut0_seq [12] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4,
                                4'hB, 4'hE, 4'hE, 4'hF};
  logic [3:0] lut5_mask_seq [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  logic [CFG_W-1:0] lut5_new = 48'h05_06_0F_3A_1234;
  logic [CFG_W-1:0] lut3_new = 48'h00_00_00_00_C0DE;

  always #5 clk = ~clk;

  s4ga_cfg_streamer #(
    .N(N),
    .K(K),
    .SI_W(SI_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .si_out     (si_out),
    .ga_rst_out (ga_rst_out),
    .lut_n      (lut_n),
    .frame_done (frame_done),
    .busy       (busy)
  );

  function automatic logic [CFG_W-1:0] mk(input logic [5:0] a, input logic [5:0] b,
                                          input logic [5:0] c, input logic [5:0] d,
                                          input logic [15:0] m);
    return {2'b00, a, 2'b00, b, 2'b00, c, 2'b00, d, m};
  endfunction

  function automatic logic [3:0] seg_of(input logic [CFG_W-1:0] w, input int s);
    logic [CFG_W-1:0] t;
    t = w >> (CFG_W - SI_W * (s + 1));
    return t[3:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, lut, s;
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    wr_addr = '0; wr_data = '0;
    tick; tick;
    chk("rst_ga_rst", 64'(ga_rst_out), 64'd1);
    chk("rst_si_out", 64'(si_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lut_n", 64'(lut_n), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < int'(N); i++) begin
      if (i == 0) exp_cfg[i] = mk(6'd1, 6'd2, 6'd3, 6'd4, 16'hBEEF);
      else exp_cfg[i] = mk(6'(i), 6'(i + 1), 6'(i * 3), 6'(63 - i),
                           16'(i * 16'h0397) ^ 16'h5A5A);
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = exp_cfg[i];
      tick;
    end
    wr_en = 1'b0;
    tick;
    chk("idle_after_writes", {62'd0, ga_rst_out, busy}, 64'b10);

    start = 1'b1;
    tick;
    start = 1'b0;
    for (int f = 0; f < int'(N); f++) begin
      chk("flush", {58'd0, ga_rst_out, busy, si_out}, {58'd0, 1'b1, 1'b1, 4'h0});
      tick;
    end

    // Two full frames plus LUTs 0..7 of a third, stop raised on LUT 7 segment 2
    for (int g = 0; g < int'(2 * FRAME + 96); g++) begin
      c = g % int'(FRAME); lut = c / int'(SEGS); s = c % int'(SEGS);
      if (g == int'(FRAME)) exp_cfg[5] = lut5_new;
      if (g == int'(2 * FRAME)) exp_cfg[3] = lut3_new;
      chk("stream", {51'd0, ga_rst_out, busy, lut_n, si_out, frame_done},
          {51'd0, 1'b0, 1'b1, 6'(lut), seg_of(exp_cfg[lut], s), c == int'(FRAME) - 1});
      if (g < 12) chk("lut0_seq", 64'(si_out), 64'(lut0_seq[g]));
      if (g >= int'(FRAME) + 68 && g < int'(FRAME) + 72)
        chk("lut5_new_mask", 64'(si_out), 64'(lut5_mask_seq[g - int'(FRAME) - 68]));
      if (frame_done) fd_count++;
      wr_en = 1'b0; stop = 1'b0;
      if (g == 63) begin
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = lut5_new;
      end
      if (g == int'(FRAME) + 34) begin
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = lut3_new;
      end
      if (g == int'(2 * FRAME) + 86) stop = 1'b1;
      tick;
    end
    wr_en = 1'b0; stop = 1'b0;
    chk("frame_done_count", 64'(fd_count), 64'd2);
    chk("idle_after_stop", {53'd0, ga_rst_out, busy, lut_n, si_out, frame_done},
        {53'd0, 1'b1, 1'b0, 6'd0, 4'h0, 1'b0});

    start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    tick;
    chk("start_stop_idle", {62'd0, ga_rst_out, busy}, 64'b10);

    start = 1'b1;
    tick;
    start = 1'b0;
    for (int f = 0; f < int'(N); f++) begin
      chk("flush_with_stop", {59'd0, ga_rst_out, si_out}, {59'd0, 1'b1, 4'h0});
      stop = (f == 10);
      tick;
    end
    stop = 1'b0;
    chk("idle_after_flush_stop", {62'd0, ga_rst_out, busy}, 64'b10);
    tick;
    chk("still_idle", {62'd0, ga_rst_out, busy}, 64'b10);

    start = 1'b1;
    tick;
    start = 1'b0;
    for (int f = 0; f < int'(N) + 20; f++) tick;
    chk("restream_lut1_seg8", {54'd0, ga_rst_out, busy, lut_n, si_out},
        {54'd0, 1'b0, 1'b1, 6'd1, seg_of(exp_cfg[1], 8)});
    rst = 1'b1;
    tick;
    chk("midrst", {53'd0, ga_rst_out, busy, lut_n, si_out, frame_done},
        {53'd0, 1'b1, 1'b0, 6'd0, 4'h0, 1'b0});
    rst = 1'b0;
    tick;
    chk("post_rst_idle", {62'd0, ga_rst_out, busy}, 64'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
